// File: rtl/game_move_sequencer_pkg.sv
// Shared types and constants for the game move sequencer: player numbering,
// sequencer FSM states and the queued command payload.
package game_move_sequencer_pkg;

  localparam int unsigned PLAYER_W    = 3;
  localparam int unsigned MOVE_W      = 3;
  localparam int unsigned NUM_PLAYERS = 6;
  localparam int unsigned LOSS_BIT    = 3;

  localparam logic [PLAYER_W-1:0] PLAYER_NONE = 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } seq_state_e;

  typedef struct packed {
    logic [PLAYER_W-1:0] player;
    logic [MOVE_W-1:0]   move;
  } cmd_t;

  function automatic logic is_legal_player(input logic [PLAYER_W-1:0] p);
    return (p != PLAYER_NONE) && (p <= PLAYER_W'(NUM_PLAYERS));
  endfunction

  // Player n (1-based) maps to strobe bit n-1; anything else yields all zeros.
  function automatic logic [NUM_PLAYERS-1:0] player_onehot(input logic [PLAYER_W-1:0] p);
    logic [NUM_PLAYERS-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      if (p == PLAYER_W'(i + 1)) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/game_move_sequencer_if.sv
// Command handshake between a command source and the game move sequencer.
interface game_move_sequencer_if;
  import game_move_sequencer_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [PLAYER_W-1:0] cmd_player;
  logic [MOVE_W-1:0]   cmd_move;

  modport master (output cmd_valid, output cmd_player, output cmd_move, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_player, input cmd_move, output cmd_ready);

endinterface

// File: rtl/game_move_sequencer_cmd_fifo.sv
// Synchronous command FIFO of {player,move} entries with count, full/empty and a
// registered not-full flag used as the upstream ready.
module game_move_sequencer_cmd_fifo
  import game_move_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  cmd_t                   i_wr_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output cmd_t                   o_rd_data,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  cmd_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ready;
  logic [CNT_W-1:0] w_count_next;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_ready   = r_ready;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_push    = i_push && !o_full;
  assign w_pop     = i_pop && !o_empty;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)      w_count_next = r_count + CNT_W'(1);
    else if (w_pop && !w_push) w_count_next = r_count - CNT_W'(1);
  end

  // Flush behaves like reset on the bookkeeping, so it also overrides a same-cycle push.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
      r_ready <= (w_count_next != CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/game_move_sequencer.sv
// Turns queued (player, move) commands into per-player move values plus a one-hot
// player_clk strobe, and latches the first loss reported by the game.
module game_move_sequencer
  import game_move_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 1,
  parameter int unsigned HOLD_CYC  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  game_move_sequencer_if.slave     cmd_if,
  input  logic                     i_flush,
  input  logic [3:0]               i_game_state,
  input  logic [2:0]               i_game_out,
  output logic [MOVE_W-1:0]        o_player1,
  output logic [MOVE_W-1:0]        o_player2,
  output logic [MOVE_W-1:0]        o_player3,
  output logic [MOVE_W-1:0]        o_player4,
  output logic [MOVE_W-1:0]        o_player5,
  output logic [MOVE_W-1:0]        o_player6,
  output logic [NUM_PLAYERS-1:0]   o_player_clk,
  output logic                     o_busy,
  output logic                     o_cmd_err,
  output logic                     o_loss_seen,
  output logic [2:0]               o_loser
);

  localparam int unsigned FIFO_CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned MAX_SP     = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned MAX_CYC    = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int unsigned CNT_W      = $clog2(MAX_CYC + 1);

  seq_state_e             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [PLAYER_W-1:0]    r_cur;
  logic [MOVE_W-1:0]      r_player [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] r_player_clk;
  logic                   r_busy;
  logic                   r_cmd_err;
  logic                   r_loss_seen;
  logic [2:0]             r_loser;

  cmd_t                   w_wr_cmd;
  cmd_t                   w_head;
  logic                   w_ready;
  logic                   w_full;
  logic                   w_empty;
  logic [FIFO_CNT_W-1:0]  w_count;
  logic                   w_accept;
  logic                   w_legal;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_unused_state;

  assign w_wr_cmd       = {cmd_if.cmd_player, cmd_if.cmd_move};
  assign w_accept       = cmd_if.cmd_valid && w_ready;
  assign w_legal        = is_legal_player(cmd_if.cmd_player);
  assign w_push         = w_accept && w_legal && !w_full;
  assign w_pop          = (r_state == ST_IDLE) && !w_empty;
  assign w_unused_state = ^i_game_state[2:0];

  game_move_sequencer_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_wr_data (w_wr_cmd),
    .i_pop     (w_pop),
    .i_flush   (i_flush),
    .o_rd_data (w_head),
    .o_empty   (w_empty),
    .o_full    (w_full),
    .o_count   (w_count),
    .o_ready   (w_ready)
  );

  // Phase counter restarts at 1 on each state entry so each phase lasts exactly its *_CYC.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_cur        <= PLAYER_NONE;
      r_player_clk <= '0;
      r_busy       <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_loss_seen  <= 1'b0;
      r_loser      <= '0;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) r_player[i] <= '0;
    end else begin
      r_cmd_err <= w_accept && !w_legal;
      r_busy    <= (r_state != ST_IDLE) || (w_count != '0);
      if (!r_loss_seen && i_game_state[LOSS_BIT]) begin
        r_loss_seen <= 1'b1;
        r_loser     <= i_game_out;
      end
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
              if (w_head.player == PLAYER_W'(i + 1)) r_player[i] <= w_head.move;
            end
            r_cur   <= w_head.player;
            r_cnt   <= CNT_W'(1);
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_cnt >= CNT_W'(SETUP_CYC)) begin
            r_player_clk <= player_onehot(r_cur);
            r_cnt        <= CNT_W'(1);
            r_state      <= ST_STROBE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_STROBE: begin
          if (r_cnt >= CNT_W'(PULSE_CYC)) begin
            r_player_clk <= '0;
            r_cnt        <= CNT_W'(1);
            r_state      <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (r_cnt >= CNT_W'(HOLD_CYC)) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_if.cmd_ready = w_ready;
  assign o_player1    = r_player[0];
  assign o_player2    = r_player[1];
  assign o_player3    = r_player[2];
  assign o_player4    = r_player[3];
  assign o_player5    = r_player[4];
  assign o_player6    = r_player[5];
  assign o_player_clk = r_player_clk;
  assign o_busy       = r_busy;
  assign o_cmd_err    = r_cmd_err;
  assign o_loss_seen  = r_loss_seen;
  assign o_loser      = r_loser;

endmodule
